debounce_array: RTL and testbench
=================================

// Module: debounce_array
// PURPOSE
//  N-channel debouncer for pushbuttons and switches. Successor to the single-input noisy_level debouncer in fpadd_system.
//  Per channel: synchroniser, stability filter, one-cycle rise/fall pulses, and long-press detection with optional auto-repeat.
//  Sits between board inputs and control FSMs such as the fpadd_system operand-step logic.
// PARAMETERS
//  CHANNELS       4     number of independent input channels (>=1)
//  SYNC_STAGES    2     synchroniser flops per channel (>=2)
//  STABLE_CYCLES  100   consecutive synced cycles required to accept a new level (>=1)
//  HOLD_CYCLES    1000  cycles of accepted-high before the first hold_pulse (>=1)
//  REPEAT_CYCLES  200   period of repeated hold_pulse after the first one; 0 = single hold_pulse only
// PORTS
//  clk          in   1         system clock
//  rst          in   1         reset, synchronous, active-high
//  noisy_in     in   CHANNELS  raw asynchronous inputs
//  clean_level  out  CHANNELS  debounced level
//  rise_pulse   out  CHANNELS  1-cycle pulse when clean_level goes 0->1
//  fall_pulse   out  CHANNELS  1-cycle pulse when clean_level goes 1->0
//  hold_pulse   out  CHANNELS  1-cycle long-press / auto-repeat pulse
//  any_rise     out  1         OR of rise_pulse (same cycle)
// BEHAVIOUR
//  - Decided: single clock clk; rst is synchronous and active-high. All outputs are registered except any_rise, which is a combinational OR of registered bits.
//  - Reset: sync flops, clean_level, all pulses, and all counters are 0. Every channel FSM goes to LOW. No pulses are emitted on reset entry or exit.
//  - Channels are fully independent. There is no arbitration, and simultaneous events on several channels all appear in the same cycle.
//  - Synchroniser: s = noisy_in delayed by SYNC_STAGES edges.
//  - Per-channel FSM:
//    - LOW: if s=1, go to CHK_HI with cnt=1.
//    - CHK_HI:
//      - s=0: return to LOW, cnt=0.
//      - s=1 and cnt<STABLE_CYCLES: cnt++.
//      - When the edge that makes cnt reach STABLE_CYCLES occurs, go to HIGH; clean_level=1, rise_pulse=1.
//    - HIGH, CHK_LO: mirror images of the above (accept s=0), ending with clean_level=0, fall_pulse=1.
//    - STABLE_CYCLES=1: the transition happens on the same edge the change is seen.
//  - Latency: noisy_in changes and is stable from before edge E. clean_level and its pulse update at edge E+SYNC_STAGES+STABLE_CYCLES-1.
//  - Glitch rule: a synced pulse shorter than STABLE_CYCLES is ignored completely. A pulse of exactly STABLE_CYCLES is accepted.
//  - Hold counter: cleared at rise; counts every cycle while clean_level=1 (HIGH or CHK_LO).
//    - Rise at edge R: hold_pulse at edges R+HOLD_CYCLES, R+HOLD_CYCLES+k*REPEAT_CYCLES, for k>=1 and only if REPEAT_CYCLES>0.
//    - The counter must never wrap into a spurious pulse. It saturates or reloads.
//  - Fall, or return to LOW via reset, clears the hold counter. No hold_pulse is emitted in the same cycle as fall_pulse.
//  - Reset mid-operation: clean_level drops to 0 with no fall_pulse.
//    - If the input is still high after rst deasserts, it is a fresh press.
//    - rise_pulse then follows at the normal latency, counted from the first non-reset edge.
//  - Pulse widths are exactly one cycle. rise_pulse and fall_pulse are never both high on the same channel.
// TESTING  (CHANNELS=2, SYNC_STAGES=2, STABLE_CYCLES=4, HOLD_CYCLES=10, REPEAT_CYCLES=3)
//  1. rst=1 for 5 cycles with noisy_in=2'b11 -> all outputs 0 throughout. After release, with inputs held high, rise_pulse=2'b11 at edge 5 after release (edge 0 = first non-reset edge).
//  2. noisy_in[0] 0->1 before edge E and held -> clean_level[0]=1 and rise_pulse[0]=1 for one cycle after edge E+5. Channel 1 outputs stay 0.
//  3. noisy_in[1] high for 3 cycles, then low -> no output change.
//     Then high for exactly 4 cycles -> rise_pulse[1] at E+5, and fall_pulse[1] 4 cycles later.
//  4. Channel 0 held 20 cycles past rise at R -> hold_pulse[0] at R+10, R+13, R+16, R+19.
//     Release -> fall_pulse[0] after 5 edges, and no hold_pulse after the release is accepted.
//     Rerun with REPEAT_CYCLES=0 -> only the pulse at R+10.
//  5. Both channels toggle on the same edge, several times -> pulses coincide each time; any_rise equals OR of rise_pulse.
//  6. rst asserted for 1 cycle while clean_level[0]=1 and the hold counter is at 8 -> clean_level=0 next edge, no fall_pulse, no hold_pulse.
//     Input still high -> rise_pulse again at +5, and the next hold_pulse at +10 from that rise.

Source files
------------

// File: rtl/debounce_array.sv
// N-channel pushbutton debouncer: synchroniser, stability filter,
// rise/fall pulses and long-press detection with optional auto-repeat.
module debounce_array #(
    parameter int CHANNELS      = 4,
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 100,
    parameter int HOLD_CYCLES   = 1000,
    parameter int REPEAT_CYCLES = 200
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] noisy_in,
    output logic [CHANNELS-1:0] clean_level,
    output logic [CHANNELS-1:0] rise_pulse,
    output logic [CHANNELS-1:0] fall_pulse,
    output logic [CHANNELS-1:0] hold_pulse,
    output logic                any_rise
);

    localparam int SW   = $clog2(STABLE_CYCLES + 1);
    localparam int HMAX = (HOLD_CYCLES > REPEAT_CYCLES) ?
                          HOLD_CYCLES : REPEAT_CYCLES;
    localparam int HW   = $clog2(HMAX + 1);

    localparam logic [SW-1:0] STABLE_LAST = SW'(STABLE_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_LAST   = HW'(HOLD_CYCLES - 1);
    localparam logic [HW-1:0] REP_LAST    =
        (REPEAT_CYCLES > 0) ? HW'(REPEAT_CYCLES - 1) : '0;

    typedef enum logic [1:0] {
        LOW,
        CHK_HI,
        HIGH,
        CHK_LO
    } state_e;

    logic [SYNC_STAGES-1:0][CHANNELS-1:0] sync_q, sync_d;

    state_e        state_q [CHANNELS];
    state_e        state_d [CHANNELS];
    logic [SW-1:0] cnt_q   [CHANNELS];
    logic [SW-1:0] cnt_d   [CHANNELS];
    logic [HW-1:0] hcnt_q  [CHANNELS];
    logic [HW-1:0] hcnt_d  [CHANNELS];

    logic [CHANNELS-1:0] rep_q, rep_d;
    logic [CHANNELS-1:0] level_q, level_d;
    logic [CHANNELS-1:0] rise_q, rise_d;
    logic [CHANNELS-1:0] fall_q, fall_d;
    logic [CHANNELS-1:0] hold_q, hold_d;
    logic [CHANNELS-1:0] s;

    assign sync_d = {sync_q[SYNC_STAGES-2:0], noisy_in};
    assign s      = sync_q[SYNC_STAGES-1];

    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            hcnt_d[i]  = hcnt_q[i];
            rep_d[i]   = rep_q[i];
            level_d[i] = level_q[i];
            rise_d[i]  = 1'b0;
            fall_d[i]  = 1'b0;
            hold_d[i]  = 1'b0;

            unique case (state_q[i])
                LOW: begin
                    if (s[i]) begin
                        if (STABLE_CYCLES == 1) begin
                            state_d[i] = HIGH;
                            level_d[i] = 1'b1;
                            rise_d[i]  = 1'b1;
                            cnt_d[i]   = '0;
                        end else begin
                            state_d[i] = CHK_HI;
                            cnt_d[i]   = SW'(1);
                        end
                    end
                end
                CHK_HI: begin
                    if (!s[i]) begin
                        state_d[i] = LOW;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == STABLE_LAST) begin
                        state_d[i] = HIGH;
                        level_d[i] = 1'b1;
                        rise_d[i]  = 1'b1;
                        cnt_d[i]   = '0;
                    end else begin
                        cnt_d[i] = cnt_q[i] + SW'(1);
                    end
                end
                HIGH: begin
                    if (!s[i]) begin
                        if (STABLE_CYCLES == 1) begin
                            state_d[i] = LOW;
                            level_d[i] = 1'b0;
                            fall_d[i]  = 1'b1;
                            cnt_d[i]   = '0;
                        end else begin
                            state_d[i] = CHK_LO;
                            cnt_d[i]   = SW'(1);
                        end
                    end
                end
                CHK_LO: begin
                    if (s[i]) begin
                        state_d[i] = HIGH;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == STABLE_LAST) begin
                        state_d[i] = LOW;
                        level_d[i] = 1'b0;
                        fall_d[i]  = 1'b1;
                        cnt_d[i]   = '0;
                    end else begin
                        cnt_d[i] = cnt_q[i] + SW'(1);
                    end
                end
                default: begin
                    state_d[i] = LOW;
                    cnt_d[i]   = '0;
                end
            endcase

            // Counter reloads after each pulse; with no repeat it parks.
            if (rise_d[i] || fall_d[i] || !level_q[i]) begin
                hcnt_d[i] = '0;
                rep_d[i]  = 1'b0;
            end else if (rep_q[i] && REPEAT_CYCLES == 0) begin
                hcnt_d[i] = hcnt_q[i];
            end else if (hcnt_q[i] == (rep_q[i] ? REP_LAST : HOLD_LAST)) begin
                hold_d[i] = 1'b1;
                hcnt_d[i] = '0;
                rep_d[i]  = 1'b1;
            end else begin
                hcnt_d[i] = hcnt_q[i] + HW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q  <= '0;
            rep_q   <= '0;
            level_q <= '0;
            rise_q  <= '0;
            fall_q  <= '0;
            hold_q  <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                state_q[i] <= LOW;
                cnt_q[i]   <= '0;
                hcnt_q[i]  <= '0;
            end
        end else begin
            sync_q  <= sync_d;
            rep_q   <= rep_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            hold_q  <= hold_d;
            for (int i = 0; i < CHANNELS; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
                hcnt_q[i]  <= hcnt_d[i];
            end
        end
    end

    assign clean_level = level_q;
    assign rise_pulse  = rise_q;
    assign fall_pulse  = fall_q;
    assign hold_pulse  = hold_q;
    assign any_rise    = |rise_q;

endmodule

// File: tb/tb_debounce_array.sv
// Randomised bench for debounce_array against a run-length reference model;
// a second instance with REPEAT_CYCLES=0 checks the single-hold mode.
module tb_debounce_array;

    localparam int CH = 2;
    localparam int SS = 2;
    localparam int ST = 4;
    localparam int HC = 10;
    localparam int RC = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [CH-1:0] noisy_in = '0;

    logic [CH-1:0] cl_a, rp_a, fp_a, hp_a;
    logic [CH-1:0] cl_b, rp_b, fp_b, hp_b;
    logic          ar_a, ar_b;

    debounce_array #(
        .CHANNELS(CH), .SYNC_STAGES(SS), .STABLE_CYCLES(ST),
        .HOLD_CYCLES(HC), .REPEAT_CYCLES(RC)
    ) dut_a (
        .clk(clk), .rst(rst), .noisy_in(noisy_in),
        .clean_level(cl_a), .rise_pulse(rp_a), .fall_pulse(fp_a),
        .hold_pulse(hp_a), .any_rise(ar_a)
    );

    debounce_array #(
        .CHANNELS(CH), .SYNC_STAGES(SS), .STABLE_CYCLES(ST),
        .HOLD_CYCLES(HC), .REPEAT_CYCLES(0)
    ) dut_b (
        .clk(clk), .rst(rst), .noisy_in(noisy_in),
        .clean_level(cl_b), .rise_pulse(rp_b), .fall_pulse(fp_b),
        .hold_pulse(hp_b), .any_rise(ar_b)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Reference model: synced sample history, run length, rise edge index.
    bit m_clean [CH];
    bit m_prev  [CH];
    int m_run   [CH];
    bit m_dly   [CH][SS];
    int m_rise_t[CH];

    logic [CH-1:0] e_clean, e_rise, e_fall, e_hold3, e_hold0;

    task automatic check(input string tag, input logic [7:0] got,
                         input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    function automatic bit hold_due(input int d, input int rep);
        if (d == HC) return 1'b1;
        return rep > 0 && d > HC && ((d - HC) % rep) == 0;
    endfunction

    task automatic model_step();
        bit sv;
        int d;
        cyc++;
        for (int c = 0; c < CH; c++) begin
            e_rise[c]  = 1'b0;
            e_fall[c]  = 1'b0;
            e_hold3[c] = 1'b0;
            e_hold0[c] = 1'b0;
            if (rst) begin
                m_clean[c] = 1'b0;
                m_prev[c]  = 1'b0;
                m_run[c]   = 0;
                for (int k = 0; k < SS; k++) m_dly[c][k] = 1'b0;
            end else begin
                sv = m_dly[c][SS-1];
                m_run[c] = (sv == m_prev[c]) ? m_run[c] + 1 : 1;
                m_prev[c] = sv;
                if (sv != m_clean[c] && m_run[c] >= ST) begin
                    m_clean[c] = sv;
                    if (sv) begin
                        e_rise[c] = 1'b1;
                        m_rise_t[c] = cyc;
                    end else begin
                        e_fall[c] = 1'b1;
                    end
                end else if (m_clean[c]) begin
                    d = cyc - m_rise_t[c];
                    e_hold3[c] = hold_due(d, RC);
                    e_hold0[c] = hold_due(d, 0);
                end
                for (int k = SS - 1; k > 0; k--) m_dly[c][k] = m_dly[c][k-1];
                m_dly[c][0] = noisy_in[c];
            end
            e_clean[c] = m_clean[c];
        end
    endtask

    task automatic step(input logic [CH-1:0] n, input logic r);
        noisy_in = n;
        rst      = r;
        @(posedge clk);
        model_step();
        #1;
        check("clean_a", 8'(cl_a), 8'(e_clean));
        check("rise_a",  8'(rp_a), 8'(e_rise));
        check("fall_a",  8'(fp_a), 8'(e_fall));
        check("hold_a",  8'(hp_a), 8'(e_hold3));
        check("anyr_a",  8'(ar_a), 8'(|e_rise));
        check("clean_b", 8'(cl_b), 8'(e_clean));
        check("rise_b",  8'(rp_b), 8'(e_rise));
        check("fall_b",  8'(fp_b), 8'(e_fall));
        check("hold_b",  8'(hp_b), 8'(e_hold0));
        check("anyr_b",  8'(ar_b), 8'(|e_rise));
    endtask

    initial begin
        int mode;
        int len;
        logic [CH-1:0] v;

        // Reset with inputs high, then release: rise on both at edge 5.
        repeat (5) step(2'b11, 1'b1);
        repeat (8) step(2'b11, 1'b0);
        repeat (8) step(2'b00, 1'b0);

        // Single channel press.
        repeat (8) step(2'b01, 1'b0);

        // Channel 1 glitch of 3, then a pulse of exactly 4.
        repeat (3)  step(2'b11, 1'b0);
        repeat (6)  step(2'b01, 1'b0);
        repeat (4)  step(2'b11, 1'b0);
        repeat (12) step(2'b01, 1'b0);

        // Long press on channel 0 then release.
        repeat (10) step(2'b01, 1'b0);
        repeat (10) step(2'b00, 1'b0);

        // Both channels toggle together.
        repeat (4) begin
            repeat (7) step(2'b11, 1'b0);
            repeat (7) step(2'b00, 1'b0);
        end

        // Reset while held, hold counter at 8, then fresh press.
        repeat (14) step(2'b01, 1'b0);
        step(2'b01, 1'b1);
        repeat (25) step(2'b01, 1'b0);
        repeat (8)  step(2'b00, 1'b0);

        for (int seg = 0; seg < 300; seg++) begin
            mode = $urandom_range(0, 19);
            v    = CH'($urandom);
            if (mode < 12) begin
                len = $urandom_range(1, 6);
                repeat (len) step(v, 1'b0);
            end else if (mode < 19) begin
                len = $urandom_range(4, 30);
                repeat (len) step(v, 1'b0);
            end else begin
                len = $urandom_range(1, 2);
                repeat (len) step(v, 1'b1);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
